// File: rtl/fdtd_mem_loader.sv
// Fetches a contiguous block of previous-timestep field words from data memory
// and streams them into the FDTD accelerator buffer with start/valid/end strobes.
module fdtd_mem_loader #(
  parameter int unsigned FDTD_DATA_WIDTH = 32,
  parameter int unsigned MEM_ADDR_WIDTH  = 32,
  parameter int unsigned REG_SIZE_WIDTH  = 16,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       load_start_i,
  input  logic [1:0]                 load_sel_i,
  input  logic [MEM_ADDR_WIDTH-1:0]  base_addr_i,
  input  logic [REG_SIZE_WIDTH-1:0]  len_i,
  output logic                       data_req_o,
  output logic [MEM_ADDR_WIDTH-1:0]  data_addr_o,
  output logic                       data_we_o,
  input  logic                       data_gnt_i,
  input  logic                       data_rvalid_i,
  input  logic [FDTD_DATA_WIDTH-1:0] data_rdata_i,
  output logic                       buffer_Hy_start_o,
  output logic                       buffer_Ez_start_o,
  output logic                       buffer_src_start_o,
  output logic                       buffer_Hy_end_o,
  output logic                       buffer_Ez_end_o,
  output logic                       buffer_src_end_o,
  output logic                       wrtvalid_Hy_old_o,
  output logic                       wrtvalid_Ez_old_o,
  output logic [FDTD_DATA_WIDTH-1:0] Hy_old_o,
  output logic [FDTD_DATA_WIDTH-1:0] Ez_old_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int unsigned OUT_W   = 2;
  localparam logic [1:0]  SEL_HY  = 2'd0;
  localparam logic [1:0]  SEL_RSV = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_FETCH,
    ST_DRAIN,
    ST_END
  } state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 sel_q, sel_d;
  logic [MEM_ADDR_WIDTH-1:0]  base_q, base_d;
  logic [REG_SIZE_WIDTH-1:0]  len_q, len_d;
  logic [REG_SIZE_WIDTH-1:0]  issued_q, issued_d;
  logic [REG_SIZE_WIDTH-1:0]  received_q, received_d;
  logic [OUT_W-1:0]           outstanding_q, outstanding_d;
  logic                       req_q, req_d;
  logic [MEM_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [FDTD_DATA_WIDTH-1:0] hy_q, hy_d, ez_q, ez_d;
  logic                       vld_hy_q, vld_hy_d, vld_ez_q, vld_ez_d;
  logic [2:0]                 start_q, start_d, end_q, end_d;
  logic                       busy_q, busy_d, done_q, done_d;
  logic                       grant, accept;

  // Next-state, counters and registered-output values
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    base_d        = base_q;
    len_d         = len_q;
    issued_d      = issued_q;
    received_d    = received_q;
    hy_d          = hy_q;
    ez_d          = ez_q;
    vld_hy_d      = 1'b0;
    vld_ez_d      = 1'b0;
    grant         = req_q & data_gnt_i;
    accept        = data_rvalid_i & busy_q & (outstanding_q != '0);
    outstanding_d = outstanding_q + OUT_W'(grant) - OUT_W'(accept);

    if (grant) begin
      issued_d = issued_q + REG_SIZE_WIDTH'(1);
    end
    if (accept) begin
      received_d = received_q + REG_SIZE_WIDTH'(1);
      if (sel_q == SEL_HY) begin
        hy_d     = data_rdata_i;
        vld_hy_d = 1'b1;
      end else begin
        ez_d     = data_rdata_i;
        vld_ez_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (load_start_i && (load_sel_i != SEL_RSV)) begin
          sel_d         = load_sel_i;
          base_d        = base_addr_i;
          len_d         = len_i;
          issued_d      = '0;
          received_d    = '0;
          outstanding_d = '0;
          state_d       = (len_i == '0) ? ST_END : ST_START;
        end
      end
      ST_START: state_d = ST_FETCH;
      ST_FETCH: if (issued_d == len_q) state_d = ST_DRAIN;
      ST_DRAIN: if (received_q == len_q) state_d = ST_END;
      ST_END:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Request is re-evaluated from next-cycle counters so back-to-back grants stream
    req_d   = (state_d == ST_FETCH) && (issued_d < len_q) &&
              (outstanding_d < OUT_W'(MAX_OUTSTANDING));
    addr_d  = req_d ? MEM_ADDR_WIDTH'(base_q + (MEM_ADDR_WIDTH'(issued_d) << 2)) : '0;
    start_d = (state_d == ST_START) ? (3'b001 << sel_d) : 3'b000;
    end_d   = ((state_d == ST_END) && (len_d != '0)) ? (3'b001 << sel_d) : 3'b000;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_END);
  end

  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      base_q        <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      req_q         <= 1'b0;
      addr_q        <= '0;
      hy_q          <= '0;
      ez_q          <= '0;
      vld_hy_q      <= 1'b0;
      vld_ez_q      <= 1'b0;
      start_q       <= '0;
      end_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      base_q        <= base_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      req_q         <= req_d;
      addr_q        <= addr_d;
      hy_q          <= hy_d;
      ez_q          <= ez_d;
      vld_hy_q      <= vld_hy_d;
      vld_ez_q      <= vld_ez_d;
      start_q       <= start_d;
      end_q         <= end_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign data_req_o         = req_q;
  assign data_addr_o        = addr_q;
  assign data_we_o          = 1'b0;
  assign buffer_Hy_start_o  = start_q[0];
  assign buffer_Ez_start_o  = start_q[1];
  assign buffer_src_start_o = start_q[2];
  assign buffer_Hy_end_o    = end_q[0];
  assign buffer_Ez_end_o    = end_q[1];
  assign buffer_src_end_o   = end_q[2];
  assign wrtvalid_Hy_old_o  = vld_hy_q;
  assign wrtvalid_Ez_old_o  = vld_ez_q;
  assign Hy_old_o           = hy_q;
  assign Ez_old_o           = ez_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

endmodule

// File: tb/tb_fdtd_mem_loader.sv
// Scoreboard bench for fdtd_mem_loader: a memory responder with configurable
// stalls and latency, and a monitor comparing strobes and words against a queue.
module tb_fdtd_mem_loader;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int LW   = 16;
  localparam int MAXO = 2;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          load_start_i;
  logic [1:0]    load_sel_i;
  logic [AW-1:0] base_addr_i;
  logic [LW-1:0] len_i;
  logic          data_req_o, data_we_o, data_gnt_i, data_rvalid_i;
  logic [AW-1:0] data_addr_o;
  logic [DW-1:0] data_rdata_i;
  logic          buffer_Hy_start_o, buffer_Ez_start_o, buffer_src_start_o;
  logic          buffer_Hy_end_o, buffer_Ez_end_o, buffer_src_end_o;
  logic          wrtvalid_Hy_old_o, wrtvalid_Ez_old_o;
  logic [DW-1:0] Hy_old_o, Ez_old_o;
  logic          busy_o, done_o;

  fdtd_mem_loader #(
    .FDTD_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .REG_SIZE_WIDTH(LW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .load_start_i(load_start_i), .load_sel_i(load_sel_i),
    .base_addr_i(base_addr_i), .len_i(len_i),
    .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .buffer_Hy_start_o(buffer_Hy_start_o), .buffer_Ez_start_o(buffer_Ez_start_o),
    .buffer_src_start_o(buffer_src_start_o),
    .buffer_Hy_end_o(buffer_Hy_end_o), .buffer_Ez_end_o(buffer_Ez_end_o),
    .buffer_src_end_o(buffer_src_end_o),
    .wrtvalid_Hy_old_o(wrtvalid_Hy_old_o), .wrtvalid_Ez_old_o(wrtvalid_Ez_old_o),
    .Hy_old_o(Hy_old_o), .Ez_old_o(Ez_old_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model state
  bit            active = 1'b0;
  logic [1:0]    exp_sel = '0;
  int            exp_len = 0, cmd_cyc = 0, seen = 0, first_v_cyc = 0, last_v_cyc = 0;
  logic [31:0]   exp_data[$];
  logic [31:0]   exp_addr[$];
  logic [31:0]   mem_base = '0, mem_dbase = '0;
  int            cmd_id = 0, first_stall = 0, lat_min = 1, lat_max = 1, spurious_cyc = -1;
  bit            rand_gnt = 1'b0;

  typedef struct {int due; logic [31:0] data;} ret_t;
  ret_t          pending[$];
  ret_t          r;
  int            mem_seen_id = 0, stall_cnt = 0, mem_lat, mem_due;
  bit            prev_stall = 1'b0;
  logic [31:0]   prev_addr = '0;

  function automatic logic any_out();
    return |{data_req_o, data_addr_o, data_we_o, buffer_Hy_start_o, buffer_Ez_start_o,
             buffer_src_start_o, buffer_Hy_end_o, buffer_Ez_end_o, buffer_src_end_o,
             wrtvalid_Hy_old_o, wrtvalid_Ez_old_o, Hy_old_o, Ez_old_o, busy_o, done_o};
  endfunction

  // Memory responder: in-order returns, one per grant, address checked on grant
  initial begin
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
    forever begin
      @(posedge CLK); #1;
      if (RST_N) begin
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        pending.delete();
        prev_stall = 1'b0;
      end else begin
        if (cmd_id != mem_seen_id) begin
          mem_seen_id = cmd_id;
          stall_cnt   = first_stall;
        end
        check("req_while_idle", 64'(data_req_o && !active), 64'(0));
        if (data_req_o) begin
          check("outstanding_cap", 64'(pending.size() < MAXO), 64'(1));
          check("we_low", 64'(data_we_o), 64'(0));
        end
        if (prev_stall) begin
          check("req_hold", 64'(data_req_o), 64'(1));
          check("addr_hold", 64'(data_addr_o), 64'(prev_addr));
        end
        data_rvalid_i = 1'b0;
        if (spurious_cyc == cyc) begin
          data_rvalid_i = 1'b1;
          data_rdata_i  = 32'hDEAD_BEEF;
        end else if (pending.size() != 0 && pending[0].due <= cyc) begin
          r = pending.pop_front();
          data_rvalid_i = 1'b1;
          data_rdata_i  = r.data;
        end
        data_gnt_i = 1'b0;
        if (data_req_o) begin
          if (stall_cnt > 0) stall_cnt--;
          else if (!(rand_gnt && $urandom_range(2, 0) == 0)) data_gnt_i = 1'b1;
        end
        if (data_gnt_i) begin
          if (exp_addr.size() != 0) check("req_addr", 64'(data_addr_o), 64'(exp_addr.pop_front()));
          else check("req_addr_extra", 64'(data_addr_o), 64'(~data_addr_o));
          mem_lat = int'($urandom_range(lat_max, lat_min));
          mem_due = cyc + mem_lat;
          if (pending.size() != 0 && mem_due <= pending[$].due) mem_due = pending[$].due + 1;
          r.due  = mem_due;
          r.data = mem_dbase + ((data_addr_o - mem_base) >> 2);
          pending.push_back(r);
        end
        prev_stall = data_req_o && !data_gnt_i;
        prev_addr  = data_addr_o;
      end
    end
  end

  logic [2:0]  m_st, m_en, m_path3;
  logic [1:0]  m_vld, m_dpath;
  logic        m_end_due, m_done_due;
  logic [31:0] prev_hy = '0, prev_ez = '0;

  // Output monitor: strobes, streamed words and completion timing
  always @(negedge CLK) begin
    if (!RST_N) begin
      m_path3 = (exp_sel == 2'd0) ? 3'b001 : (exp_sel == 2'd1) ? 3'b010 : 3'b100;
      m_dpath = (exp_sel == 2'd0) ? 2'b01 : 2'b10;
      m_st    = {buffer_src_start_o, buffer_Ez_start_o, buffer_Hy_start_o};
      check("start_pulse", 64'(m_st),
            64'((active && exp_len != 0 && cyc == cmd_cyc + 1) ? m_path3 : 3'b000));
      m_vld = {wrtvalid_Ez_old_o, wrtvalid_Hy_old_o};
      if (m_vld != 2'b00) begin
        check("valid_path", 64'(m_vld), 64'(active ? m_dpath : 2'b00));
        if (exp_data.size() != 0)
          check("word", 64'(m_vld[0] ? Hy_old_o : Ez_old_o), 64'(exp_data.pop_front()));
        else
          check("word_extra", 64'(m_vld), 64'(2'b00));
        check("other_hold", 64'(m_vld[0] ? Ez_old_o : Hy_old_o), 64'(m_vld[0] ? prev_ez : prev_hy));
        if (seen == 0) first_v_cyc = cyc;
        seen++;
        last_v_cyc = cyc;
      end
      m_en = {buffer_src_end_o, buffer_Ez_end_o, buffer_Hy_end_o};
      m_end_due  = active && exp_len != 0 && seen == exp_len && cyc == last_v_cyc + 1;
      check("end_pulse", 64'(m_en), 64'(m_end_due ? m_path3 : 3'b000));
      m_done_due = active && ((exp_len == 0) ? (cyc == cmd_cyc + 1) : m_end_due);
      check("done", 64'(done_o), 64'(m_done_due));
      check("busy", 64'(busy_o), 64'(active && cyc > cmd_cyc));
      if (m_done_due) active = 1'b0;
    end
    prev_hy = Hy_old_o;
    prev_ez = Ez_old_o;
  end

  task automatic issue(input logic [1:0] sel, input logic [31:0] base, input int len,
                       input logic [31:0] dbase, input int stall);
    load_start_i = 1'b1;
    load_sel_i   = sel;
    base_addr_i  = base;
    len_i        = 16'(len);
    if (!active && sel != 2'd3) begin
      active      = 1'b1;
      exp_sel     = sel;
      exp_len     = len;
      cmd_cyc     = cyc;
      seen        = 0;
      mem_base    = base;
      mem_dbase   = dbase;
      first_stall = stall;
      cmd_id++;
      for (int i = 0; i < len; i++) begin
        exp_data.push_back(dbase + 32'(i));
        exp_addr.push_back(base + 32'(4 * i));
      end
    end
    @(posedge CLK); #1;
    load_start_i = 1'b0;
    load_sel_i   = $urandom_range(3, 0);
    base_addr_i  = $urandom;
    len_i        = 16'($urandom);
  endtask

  task automatic do_reset();
    #2;
    RST_N = 1'b1;
    #1;
    check("reset_outputs_zero", 64'(any_out()), 64'(0));
    active = 1'b0;
    exp_data.delete();
    exp_addr.delete();
    @(posedge CLK); #1;
    check("reset_no_req", 64'(data_req_o), 64'(0));
    @(posedge CLK); #3;
    RST_N = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (active && n < budget) begin
      @(posedge CLK);
      n++;
    end
    #1;
    check("done_timeout", 64'(active), 64'(0));
    if (active) do_reset();
    @(posedge CLK); #1;
  endtask

  initial begin
    RST_N = 1'b1;
    load_start_i = 1'b0; load_sel_i = '0; base_addr_i = '0; len_i = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", 64'(any_out()), 64'(0));
    RST_N = 1'b0;
    @(posedge CLK); #1;

    // Hy block, immediate grant, single-cycle return latency
    issue(2'd0, 32'h100, 4, 32'hA0, 0);
    wait_done(100);
    check("throughput", 64'(last_v_cyc - first_v_cyc), 64'(3));

    // Ez block with first request stalled three cycles
    issue(2'd1, 32'h2000, 3, 32'hB0, 3);
    wait_done(100);

    // Long return latency limited by outstanding cap
    lat_min = 5; lat_max = 5;
    issue(2'd0, 32'h400, 6, 32'hC0, 0);
    wait_done(200);
    lat_min = 1; lat_max = 1;

    // Zero length, reserved select, stray return while idle
    issue(2'd0, 32'h500, 0, 32'h0, 0);
    wait_done(20);
    issue(2'd3, 32'h600, 5, 32'h0, 0);
    spurious_cyc = cyc + 1;
    repeat (4) @(posedge CLK);
    #1;

    // Address wrap and ignored command mid-transfer
    lat_max = 3;
    issue(2'd0, 32'hFFFF_FFF8, 3, 32'hD0, 0);
    issue(2'd1, 32'h700, 4, 32'hEE, 0);
    wait_done(100);
    lat_max = 1;

    // src select, then reset mid-fetch and a clean follow-up
    issue(2'd2, 32'h800, 2, 32'hE0, 0);
    wait_done(100);
    issue(2'd0, 32'h900, 8, 32'hF0, 6);
    repeat (2) @(posedge CLK);
    #1;
    do_reset();
    issue(2'd1, 32'hA00, 5, 32'h11, 0);
    wait_done(100);

    // Randomized commands with random grant gaps and latency
    rand_gnt = 1'b1;
    for (int k = 0; k < 30; k++) begin
      lat_min = 1;
      lat_max = int'($urandom_range(4, 1));
      issue(2'($urandom_range(3, 0)), $urandom, int'($urandom_range(10, 0)), $urandom,
            int'($urandom_range(2, 0)));
      if (active && $urandom_range(3, 0) == 0) begin
        @(posedge CLK); #1;
        issue(2'($urandom_range(2, 0)), $urandom, int'($urandom_range(10, 1)), $urandom, 0);
      end
      wait_done(300);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
